// File: rtl/clk_div_gen_module.sv
// Run-time programmable clock divider: divided clock, rising-edge tick strobe
// and a wrapping period counter. Divisor changes are deferred to a period boundary.
module clk_div_gen_module #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 4,
    parameter int PER_W       = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             phase_rst,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_pend,
    output logic [CNT_W-1:0] div_cur,
    output logic             clk_out,
    output logic             tick,
    output logic [PER_W-1:0] period_cnt
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_nxt;
    logic             pend;

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] div_clamped;
    logic             wrap;
    logic             boundary;

    always_comb begin
        half        = div_act - (div_act >> 1);
        cnt_inc     = cnt + ONE;
        wrap        = en && (cnt == (div_act - ONE));
        boundary    = phase_rst || wrap;
        div_clamped = (div_in < DIV_MIN) ? DIV_MIN : div_in;
    end

    // A boundary always applies the previously pending divisor; a load in the
    // same cycle only refills the pending register for the following boundary.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt        <= DIV_RST - ONE;
            div_act    <= DIV_RST;
            div_nxt    <= DIV_RST;
            pend       <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            period_cnt <= '0;
        end else begin
            if (boundary) begin
                cnt        <= '0;
                clk_out    <= 1'b1;
                tick       <= 1'b1;
                period_cnt <= period_cnt + PER_W'(1);
                if (pend) begin
                    div_act <= div_nxt;
                end
            end else if (en) begin
                cnt     <= cnt_inc;
                clk_out <= (cnt_inc < half);
                tick    <= 1'b0;
            end else begin
                tick <= 1'b0;
            end

            if (div_load) begin
                div_nxt <= div_clamped;
                pend    <= 1'b1;
            end else if (boundary) begin
                pend <= 1'b0;
            end
        end
    end

    assign div_cur  = div_act;
    assign div_pend = pend;

endmodule
